io_timer: RTL

Parametrised system-timer and GPIO register block for the RISC5 I/O page. It replaces the fixed millisecond divider, tick counter and 8-bit GPIO registers previously coded inline at the top level. It adds NCH compare channels, rising-edge capture on GPIO inputs, and a maskable, level-sensitive interrupt output to the CPU `irq`. It decodes word addresses on the I/O page. Pad buffers stay at the top level.

---
 rtl/io_timer_pkg.sv | 17 +
 rtl/gpio_sync_edge.sv | 33 +++
 rtl/io_timer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/io_timer_pkg.sv
// io_timer_pkg: register addresses and pending-word layout for the
// system-timer / GPIO block on the RISC5 I/O page.
package io_timer_pkg;

   localparam logic [3:0] A_TICK   = 4'd0;
   localparam logic [3:0] A_PEND   = 4'd1;
   localparam logic [3:0] A_IEN    = 4'd2;
   localparam logic [3:0] A_GPIN   = 4'd3;
   localparam logic [3:0] A_GPOUT  = 4'd4;
   localparam logic [3:0] A_GPOE   = 4'd5;
   localparam logic [3:0] A_GPRISE = 4'd6;
   localparam logic [3:0] A_CMP0   = 4'd8;

   // GPIO-edge pending bits start here in the PEND and IEN words
   localparam int GPIO_BASE = 16;

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: brings asynchronous pad inputs into the clk domain with a
// two-flop synchroniser and flags a rising edge on the synchronised value.
module gpio_sync_edge #(
   parameter int GPW = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [GPW-1:0] pin,
   output logic [GPW-1:0] sync,
   output logic [GPW-1:0] rise
);

   logic [GPW-1:0] s1;
   logic [GPW-1:0] s2;
   logic [GPW-1:0] s3;

   // s1/s2 resolve metastability; s3 holds the previous synchronised value
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= pin;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign sync = s2;
   assign rise = s2 & ~s3;

endmodule

// File: rtl/io_timer.sv
// io_timer: millisecond prescaler, tick counter with NCH compare channels,
// GPIO output/enable registers, GPIO rising-edge capture and a maskable,
// level-sensitive irq, all decoded as word registers on the I/O page.
module io_timer
   import io_timer_pkg::*;
#(
   parameter int DIV = 25000,
   parameter int CW  = 32,
   parameter int NCH = 2,
   parameter int GPW = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           sel,
   input  logic           wr,
   input  logic [3:0]     iowadr,
   input  logic [31:0]    wdata,
   output logic [31:0]    rdata,
   output logic           irq,
   input  logic [GPW-1:0] gpin,
   output logic [GPW-1:0] gpout,
   output logic [GPW-1:0] gpoe
);

   localparam int PW = $clog2(DIV);
   localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

   if (NCH < 1 || NCH > 4) begin : g_bad_nch
      $error("io_timer: NCH must be in 1..4");
   end
   if (GPW < 1 || GPW > 16) begin : g_bad_gpw
      $error("io_timer: GPW must be in 1..16");
   end
   if (DIV < 2) begin : g_bad_div
      $error("io_timer: DIV must be at least 2");
   end
   if (CW < 8 || CW > 32) begin : g_bad_cw
      $error("io_timer: CW must be in 8..32");
   end

   logic [PW-1:0]  pre;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  cnt_inc;
   logic [CW-1:0]  cmp [NCH];
   logic [NCH-1:0] pend_cmp;
   logic [NCH-1:0] ien_cmp;
   logic [NCH-1:0] clr_cmp;
   logic [NCH-1:0] cmp_hit;
   logic [GPW-1:0] pend_gp;
   logic [GPW-1:0] ien_gp;
   logic [GPW-1:0] clr_gp;
   logic [GPW-1:0] gprise;
   logic [GPW-1:0] gp_sync;
   logic [GPW-1:0] gp_rise;
   logic [GPW-1:0] gp_event;
   logic           we;
   logic           tick;
   logic           tick_wr;

   // Pack compare bits at the bottom and GPIO bits at GPIO_BASE
   function automatic logic [31:0] pend_layout(input logic [NCH-1:0] c,
                                               input logic [GPW-1:0] g);
      pend_layout = '0;
      pend_layout[NCH-1:0] = c;
      pend_layout[GPIO_BASE +: GPW] = g;
   endfunction

   gpio_sync_edge #(.GPW(GPW)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .pin  (gpin),
      .sync (gp_sync),
      .rise (gp_rise)
   );

   assign we       = sel & wr;
   assign tick_wr  = we && (iowadr == A_TICK);
   assign tick     = (pre == PRE_MAX);
   assign cnt_inc  = cnt + 1'b1;
   assign gp_event = gp_rise & gprise;
   assign clr_cmp  = (we && (iowadr == A_PEND)) ? wdata[NCH-1:0] : '0;
   assign clr_gp   = (we && (iowadr == A_PEND)) ? wdata[GPIO_BASE +: GPW] : '0;

   // A compare matches on a tick the counter is about to reach, unless a TICK write overrides that tick
   always_comb begin
      cmp_hit = '0;
      for (int k = 0; k < NCH; k++) begin
         cmp_hit[k] = tick && !tick_wr && (cnt_inc == cmp[k]);
      end
   end

   // Prescaler and tick counter; a TICK write reloads the count and restarts the prescaler
   always_ff @(posedge clk) begin
      if (rst) begin
         pre <= '0;
         cnt <= '0;
      end else if (tick_wr) begin
         pre <= '0;
         cnt <= wdata[CW-1:0];
      end else if (tick) begin
         pre <= '0;
         cnt <= cnt_inc;
      end else begin
         pre <= pre + 1'b1;
      end
   end

   // Plain read/write configuration registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ien_cmp <= '0;
         ien_gp  <= '0;
         gpout   <= '0;
         gpoe    <= '0;
         gprise  <= '0;
         for (int k = 0; k < NCH; k++) begin
            cmp[k] <= '0;
         end
      end else if (we) begin
         case (iowadr)
            A_IEN: begin
               ien_cmp <= wdata[NCH-1:0];
               ien_gp  <= wdata[GPIO_BASE +: GPW];
            end
            A_GPOUT:  gpout  <= wdata[GPW-1:0];
            A_GPOE:   gpoe   <= wdata[GPW-1:0];
            A_GPRISE: gprise <= wdata[GPW-1:0];
            default: ;
         endcase
         for (int k = 0; k < NCH; k++) begin
            if (iowadr == 4'(A_CMP0 + k)) begin
               cmp[k] <= wdata[CW-1:0];
            end
         end
      end
   end

   // Sticky pending bits with write-1-to-clear where a same-cycle set wins; irq follows one cycle behind
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_cmp <= '0;
         pend_gp  <= '0;
         irq      <= 1'b0;
      end else begin
         pend_cmp <= (pend_cmp & ~clr_cmp) | cmp_hit;
         pend_gp  <= (pend_gp & ~clr_gp) | gp_event;
         irq      <= (|(pend_cmp & ien_cmp)) || (|(pend_gp & ien_gp));
      end
   end

   // Combinational read mux; unmapped addresses return zero
   always_comb begin
      rdata = '0;
      case (iowadr)
         A_TICK:   rdata[CW-1:0]  = cnt;
         A_PEND:   rdata          = pend_layout(pend_cmp, pend_gp);
         A_IEN:    rdata          = pend_layout(ien_cmp, ien_gp);
         A_GPIN:   rdata[GPW-1:0] = gp_sync;
         A_GPOUT:  rdata[GPW-1:0] = gpout;
         A_GPOE:   rdata[GPW-1:0] = gpoe;
         A_GPRISE: rdata[GPW-1:0] = gprise;
         default: begin
            for (int k = 0; k < NCH; k++) begin
               if (iowadr == 4'(A_CMP0 + k)) begin
                  rdata[CW-1:0] = cmp[k];
               end
            end
         end
      endcase
   end

endmodule
